// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and the scan classifier for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int KEY_W    = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_SINGLE = 2'd1,
        CLS_MULTI  = 2'd2
    } scan_class_e;

    typedef struct packed {
        scan_class_e      cls;
        logic [KEY_W-1:0] code;
    } scan_eval_t;

    // Classifies a completed snapshot; code is only meaningful for CLS_SINGLE.
    function automatic scan_eval_t classify_scan(input logic [NUM_KEYS-1:0] snap);
        scan_eval_t res;
        logic [4:0] ones;
        res.cls  = CLS_NONE;
        res.code = '0;
        ones     = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (snap[i]) begin
                ones     = ones + 5'd1;
                res.code = KEY_W'(i);
            end
        end
        if (ones == 5'd1) begin
            res.cls = CLS_SINGLE;
        end else if (ones > 5'd1) begin
            res.cls = CLS_MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and key-event signals of the scanner, bundled for port connection.
interface keypad_scanner_if;
    import keypad_pkg::*;

    // key_valid is a one-cycle strobe with no ready/backpressure: the consumer must
    // sample it every cycle. key_code is stable from that strobe until the next
    // accepted press; key_held is a level covering press-to-release.
    logic [NUM_ROWS-1:0] row;
    logic [NUM_COLS-1:0] col;
    logic [KEY_W-1:0]    key_code;
    logic                key_valid;
    logic                key_held;

    modport master (
        output row,
        input  col,
        input  key_code,
        input  key_valid,
        input  key_held
    );

    modport slave (
        input  row,
        output col,
        output key_code,
        output key_valid,
        output key_held
    );

endinterface

// File: rtl/scan_timer.sv
// Column slot timer: a tick every SCAN_TICKS cycles and a rotating active-low column drive.
module scan_timer import keypad_pkg::*; #(
    parameter int SCAN_TICKS = 41666
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                tick_o,
    output logic [1:0]          col_idx_o,
    output logic [NUM_COLS-1:0] col_o
);

    localparam int            TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;

    assign tick_o    = (tick_cnt_q == TICK_LAST);
    assign col_idx_o = col_idx_q;

    always_comb begin
        tick_cnt_d = tick_cnt_q + TW'(1);
        col_idx_d  = col_idx_q;
        if (tick_o) begin
            tick_cnt_d = '0;
            col_idx_d  = col_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            col_idx_q  <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            col_idx_q  <= col_idx_d;
        end
    end

    always_comb begin
        col_o            = '1;
        col_o[col_idx_q] = 1'b0;
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row synchronizer, per-scan snapshot and a debounce FSM
// that accepts one key press at a time and reports it as a strobe plus a held level.
module keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_TICKS     = 41666,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    keypad_scanner_if.slave  bus,
    output kp_state_e        dbg_state_o
);

    localparam logic [CNT_W-1:0] DS_LAST = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                tick;
    logic [1:0]          col_idx;
    logic [NUM_COLS-1:0] col;

    logic [NUM_ROWS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic                scan_done_q;

    kp_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [KEY_W-1:0]    cand_q, cand_d;
    logic [KEY_W-1:0]    key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;

    scan_eval_t          scan_res;
    logic [CNT_W-1:0]    cnt_inc;

    scan_timer #(
        .SCAN_TICKS (SCAN_TICKS)
    ) u_scan_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_o    (tick),
        .col_idx_o (col_idx),
        .col_o     (col)
    );

    // Rows are inverted into the snapshot so a set bit means "key down".
    always_comb begin
        snap_d = snap_q;
        if (tick) begin
            snap_d[{col_idx, 2'b00} +: NUM_ROWS] = ~sync2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            snap_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            sync1_q     <= bus.row;
            sync2_q     <= sync1_q;
            snap_q      <= snap_d;
            scan_done_q <= tick && (col_idx == 2'd3);
        end
    end

    assign scan_res = classify_scan(snap_q);
    assign cnt_inc  = cnt_q + CNT_ONE;

    // The FSM only moves in the cycle after the column-3 tick, when snap_q is complete.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (scan_done_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_res.cls == CLS_SINGLE) begin
                        cand_d = scan_res.code;
                        if (DS_LAST == CNT_ONE) begin
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                            key_code_d  = scan_res.code;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if ((scan_res.cls == CLS_SINGLE) && (scan_res.code == cand_q)) begin
                        if (cnt_inc == DS_LAST) begin
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (scan_res.cls == CLS_NONE) begin
                        if (DS_LAST == CNT_ONE) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (scan_res.cls == CLS_NONE) begin
                        if (cnt_inc == DS_LAST) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign bus.col       = col;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.key_held  = (state_q == ST_PRESSED) || (state_q == ST_RELEASE);
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a 4-cycle column slot and 2-scan debounce (16 cycles/scan).
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_TICKS = 4;
    localparam int DS         = 2;
    localparam int SCAN_CYC   = SCAN_TICKS * NUM_COLS;
    localparam int RND_SCANS  = 150;

    typedef struct {
        logic [15:0] keys;
        int          scans;
        int          pulses;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    logic        clk;
    logic        reset_n;
    logic [15:0] keys_v;
    kp_state_e   dbg_state;

    int n_checks;
    int n_fail;
    int pulse_cnt;
    int cyc_cnt;
    int last_pulse_cyc;

    logic [3:0] exp_q[$];

    keypad_scanner_if kif();

    keypad_scanner #(
        .SCAN_TICKS     (SCAN_TICKS),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (kif.slave),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        kif.row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (kif.col[c] == 1'b0) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys_v[c*4+r]) kif.row[r] = 1'b0;
                end
            end
        end
    end

    // ---------------- driver / checker tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Advance n cycles; we always sit at a negedge, and record key_valid strobes.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc_cnt++;
            if (kif.key_valid === 1'b1) begin
                pulse_cnt++;
                last_pulse_cyc = cyc_cnt;
            end
        end
    endtask

    // Called at a negedge; holds reset for n rising edges and leaves us in cycle 0.
    task automatic do_reset(input int n);
        reset_n = 1'b0;
        for (int i = 0; i < n; i++) @(negedge clk);
        reset_n = 1'b1;
        cyc_cnt = 0;
    endtask

    // ---------------- scan-level reference model ----------------
    int         m_streak;
    logic [3:0] m_cand;
    logic [3:0] m_code;
    logic       m_held;
    logic       m_valid;
    int         m_accepts;

    task automatic model_reset();
        m_streak  = 0;
        m_cand    = '0;
        m_code    = '0;
        m_held    = 1'b0;
        m_valid   = 1'b0;
        m_accepts = 0;
        exp_q.delete();
    endtask

    // One full scan of key set pat: a press needs DS consecutive scans of the same lone key,
    // a release needs DS consecutive empty scans; a breaking scan restarts the run from zero.
    task automatic model_scan(input logic [15:0] pat);
        int         ones;
        logic [3:0] code;
        ones    = $countones(pat);
        code    = '0;
        for (int i = 0; i < 16; i++) if (pat[i]) code = 4'(i);
        m_valid = 1'b0;
        if (!m_held) begin
            if (ones == 1 && (m_streak == 0 || code == m_cand)) begin
                if (m_streak == 0) m_cand = code;
                m_streak++;
                if (m_streak == DS) begin
                    m_held   = 1'b1;
                    m_streak = 0;
                    m_code   = m_cand;
                    m_valid  = 1'b1;
                    m_accepts++;
                    exp_q.push_back(m_cand);
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (ones == 0) begin
                m_streak++;
                if (m_streak == DS) begin
                    m_held   = 1'b0;
                    m_streak = 0;
                end
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic rnd_check();
        logic [3:0] exp_code;
        check("rnd_valid", kif.key_valid, m_valid);
        check("rnd_code", kif.key_code, m_code);
        check("rnd_held", kif.key_held, m_held);
        if (kif.key_valid === 1'b1 && exp_q.size() > 0) begin
            exp_code = exp_q.pop_front();
            check("rnd_sb_code", kif.key_code, exp_code);
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs[16];

    initial begin
        int          p0;
        logic [3:0]  exp_col;
        logic [15:0] pat;
        int          a;
        int          sel;

        vecs[0]  = '{16'h0000,  3, 0, 4'h0, 1'b0};
        vecs[1]  = '{16'h0040,  4, 1, 4'h6, 1'b1};
        vecs[2]  = '{16'h0000,  4, 0, 4'h6, 1'b0};
        vecs[3]  = '{16'h0021, 10, 0, 4'h6, 1'b0};
        vecs[4]  = '{16'h0001,  4, 1, 4'h0, 1'b1};
        vecs[5]  = '{16'h0021,  3, 0, 4'h0, 1'b1};
        vecs[6]  = '{16'h0000,  3, 0, 4'h0, 1'b0};
        vecs[7]  = '{16'h8000,  3, 1, 4'hF, 1'b1};
        vecs[8]  = '{16'h0000,  1, 0, 4'hF, 1'b1};
        vecs[9]  = '{16'h8000,  1, 0, 4'hF, 1'b1};
        vecs[10] = '{16'h0000,  1, 0, 4'hF, 1'b1};
        vecs[11] = '{16'h0000,  3, 0, 4'hF, 1'b0};
        vecs[12] = '{16'h0008,  1, 0, 4'hF, 1'b0};
        vecs[13] = '{16'h0010,  1, 0, 4'hF, 1'b0};
        vecs[14] = '{16'h0008,  1, 0, 4'hF, 1'b0};
        vecs[15] = '{16'h0000,  3, 0, 4'hF, 1'b0};

        n_checks       = 0;
        n_fail         = 0;
        pulse_cnt      = 0;
        cyc_cnt        = 0;
        last_pulse_cyc = -1;
        keys_v         = '0;
        model_reset();

        // Reset values, then 100 idle cycles of column rotation.
        do_reset(3);
        check("rst_col", kif.col, 4'b1110);
        check("rst_valid", kif.key_valid, 1'b0);
        check("rst_held", kif.key_held, 1'b0);
        check("rst_code", kif.key_code, 4'h0);
        check("rst_state", dbg_state, ST_IDLE);
        p0 = pulse_cnt;
        for (int k = 0; k < 100; k++) begin
            cyc(1);
            exp_col = ~(4'b0001 << ((cyc_cnt / 4) % 4));
            check("idle_col", kif.col, exp_col);
        end
        check("idle_pulses", pulse_cnt - p0, 0);
        check("idle_held", kif.key_held, 1'b0);
        check("idle_code", kif.key_code, 4'h0);

        // Table of held key patterns; each row holds its pattern for whole scans.
        do_reset(2);
        for (int v = 0; v < 16; v++) begin
            keys_v = vecs[v].keys;
            p0     = pulse_cnt;
            cyc(SCAN_CYC * vecs[v].scans);
            check($sformatf("vec%0d_pulses", v), pulse_cnt - p0, vecs[v].pulses);
            check($sformatf("vec%0d_code", v), kif.key_code, vecs[v].code);
            check($sformatf("vec%0d_held", v), kif.key_held, vecs[v].held);
        end

        // Bounce: key 6 toggles every 8 cycles for 64 cycles, then held.
        keys_v = '0;
        do_reset(2);
        p0 = pulse_cnt;
        for (int i = 0; i < 8; i++) begin
            keys_v = (i % 2 == 1) ? 16'h0040 : 16'h0000;
            cyc(8);
        end
        check("bounce_no_pulse", pulse_cnt - p0, 0);
        keys_v = 16'h0040;
        cyc(64);
        check("bounce_pulses", pulse_cnt - p0, 1);
        check("bounce_pulse_cyc", last_pulse_cyc, 97);
        check("bounce_code", kif.key_code, 4'h6);
        check("bounce_held", kif.key_held, 1'b1);

        // Reset in the middle of a debounce discards it.
        keys_v = '0;
        do_reset(2);
        keys_v = 16'h0040;
        cyc(48);
        keys_v = 16'h0000;
        cyc(64);
        check("pre_rst_code", kif.key_code, 4'h6);
        keys_v = 16'h0200;
        p0 = pulse_cnt;
        cyc(20);
        check("pre_rst_state", dbg_state, ST_DEBOUNCE);
        do_reset(1);
        check("midrst_col", kif.col, 4'b1110);
        check("midrst_code", kif.key_code, 4'h0);
        check("midrst_held", kif.key_held, 1'b0);
        check("midrst_valid", kif.key_valid, 1'b0);
        check("midrst_state", dbg_state, ST_IDLE);
        cyc(48);
        check("midrst_pulses", pulse_cnt - p0, 1);
        check("midrst_pulse_cyc", last_pulse_cyc, 33);
        check("midrst_new_code", kif.key_code, 4'h9);

        // Randomized key patterns against the scan-level model.
        keys_v = '0;
        do_reset(2);
        model_reset();
        p0  = pulse_cnt;
        pat = '0;
        for (int n = 0; n < RND_SCANS; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 5);
                if (sel <= 1) begin
                    pat = '0;
                end else if (sel <= 4) begin
                    pat = 16'h0001 << $urandom_range(0, 15);
                end else begin
                    a   = $urandom_range(0, 15);
                    pat = (16'h0001 << a) | (16'h0001 << ((a + $urandom_range(1, 15)) % 16));
                end
            end
            keys_v = pat;
            cyc(1);
            rnd_check();
            model_scan(pat);
            cyc(SCAN_CYC - 1);
        end
        cyc(1);
        rnd_check();
        check("rnd_sb_empty", exp_q.size(), 0);
        check("rnd_total_pulses", pulse_cnt - p0, m_accepts);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_TICKS, default 41666, clock cycles per column slot; legal minimum 4.
REQ-002 Parameter DEBOUNCE_SCANS, default 4, consecutive identical full scans needed to accept a press or a release; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  column drive, active-low, exactly one bit low at all times.
REQ-007 key_code  output  4  accepted key index = col_index*4 + row_index.
REQ-008 key_valid  output  1  one-cycle strobe on each accepted press.
REQ-009 key_held  output  1  level, high from accepted press until accepted release.

Function
REQ-010 The tick counter SHALL count 0..SCAN_TICKS-1 and wrap; tick SHALL be high in the cycle where count = SCAN_TICKS-1.
REQ-011 A 2-bit column index SHALL advance on tick and wrap 3->0; col SHALL be the active-low one-hot decode of the index (index 0 -> 4'b1110).
REQ-012 row SHALL pass through a 2-flop synchronizer before use; no other logic SHALL read raw row.
REQ-013 On tick, the synchronized row value, inverted, SHALL be written into the 16-bit snapshot bits [idx*4+3 : idx*4] for the current column index.
REQ-014 A tick with column index 3 SHALL mark scan-complete; evaluation SHALL occur in the following cycle on the completed snapshot.
REQ-015 Evaluation classes: NONE (0 bits set), SINGLE (exactly 1 bit set, code = bit position), MULTI (2 or more bits set).
REQ-016 FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE; transitions occur only in evaluation cycles.
REQ-017 IDLE: SINGLE -> DEBOUNCE, cand = code, cnt = 1, with an immediate DEBOUNCE_SCANS check; NONE or MULTI -> stay.
REQ-018 DEBOUNCE: SINGLE with code = cand -> cnt+1; any other class or code -> IDLE, cnt = 0.
REQ-019 When cnt reaches DEBOUNCE_SCANS in IDLE/DEBOUNCE -> PRESSED; key_code SHALL load cand and key_valid SHALL be high for exactly the next clk cycle.
REQ-020 PRESSED: NONE -> RELEASE, cnt = 1, with an immediate DEBOUNCE_SCANS check; SINGLE or MULTI -> stay; key_valid SHALL NOT re-fire.
REQ-021 RELEASE: NONE -> cnt+1; SINGLE or MULTI -> PRESSED, cnt = 0.
REQ-022 When cnt reaches DEBOUNCE_SCANS in RELEASE -> IDLE, key_held low from the next cycle.
REQ-023 key_held SHALL be high exactly while the state is PRESSED or RELEASE.
REQ-024 key_code SHALL hold its last accepted value until the next accepted press.
REQ-025 cnt SHALL be 4 bits and SHALL never exceed DEBOUNCE_SCANS.
REQ-026 MULTI SHALL never produce key_valid.

Reset
REQ-027 While reset_n = 0 at a clk edge: tick counter 0, column index 0 (col = 4'b1110), synchronizer flops 4'b1111, snapshot 0, state IDLE, cnt 0, cand 0, key_code 0, key_valid 0, key_held 0.
REQ-028 Reset mid-debounce or mid-press SHALL discard all progress; no key_valid SHALL be emitted for a press begun before reset.

Structure
REQ-029 Shared package/header keypad_pkg SHALL hold the FSM state encodings, the KEY_W = 4 width constant, and the NUM_COLS = NUM_ROWS = 4 constants.
REQ-030 The tick/column generator SHALL be one sub-module, scan_timer, with synchronous active-low reset; the FSM, snapshot, and synchronizer SHALL live in keypad_scanner.

Verification (SCAN_TICKS = 4, DEBOUNCE_SCANS = 2; one scan = 16 cycles)
REQ-031 Reset, then idle 100 cycles -> col cycles 1110, 1101, 1011, 0111, each for 4 cycles; key_valid = 0, key_held = 0, key_code = 0.
REQ-032 Hold row[2] low while col = 1101 -> exactly one key_valid with key_code = 4'h6 within 3 scans of press onset; key_held = 1 while held.
REQ-033 Release after REQ-032 -> key_held falls within 3 scans of release; no additional key_valid.
REQ-034 Bounce: toggle the key every 8 cycles for 64 cycles, then hold -> exactly one key_valid, and only after stable hold.
REQ-035 Press keys 0 and 5 simultaneously for 10 scans -> no key_valid; releasing key 5 -> one key_valid with key_code = 0.
REQ-036 Assert reset_n = 0 for 1 cycle during DEBOUNCE -> all outputs at reset values next cycle; a fresh key_valid requires a full new debounce.
